imm_extend_stage: RTL and testbench
===================================

# imm_extend_stage

Registered, parametrised immediate-extension stage for the decode path. Takes a 32-bit RV instruction plus a 3-bit immediate-format select and returns the XLEN-wide sign- or zero-extended immediate one cycle later. Input and output both use valid/ready handshakes, and a 2-entry skid buffer sustains one transfer per cycle under backpressure. It also adds shift-amount and CSR-uimm formats, flags illegal selects, keeps a saturating illegal-select counter, and supports a synchronous flush.

## Interface
- XLEN, 32: output width; legal values are 32 and 64.
- TAG_W, 4: width of the sideband tag passed through with each entry.
- CNT_W, 8: width of the illegal-select counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  input entry present.
- in_ready  out  1  stage can accept an entry.
- in_instr  in  32  instruction word.
- in_imm_src  in  3  immediate format select.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  output entry present.
- out_ready  in  1  consumer accepts the output entry.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag belonging to out_imm.
- out_illegal  out  1  entry carried an illegal in_imm_src.
- err_cnt  out  CNT_W  saturating count of accepted illegal entries.

## Operation
- Formats (i = in_instr; sx = sign-extend from bit 31 to XLEN; zx = zero-extend):
  - 000 I: sx(i[31:20]).
  - 001 S: sx({i[31:25], i[11:7]}).
  - 010 B: sx({i[31], i[7], i[30:25], i[11:8], 0}).
  - 011 U: sx({i[31:12], 12'b0}); for XLEN=64, bits 63:32 are copies of i[31].
  - 100 J: sx({i[31], i[19:12], i[20], i[30:21], 0}).
  - 101 SHAMT: zx(i[24:20]) when XLEN=32; zx(i[25:20]) when XLEN=64.
  - 110 ZIMM: zx(i[19:15]).
  - 111 illegal: imm = 0 and out_illegal = 1. No simulation messages are printed.
- The immediate is computed combinationally at the input; the stored value is the final immediate.
- Storage is an output register (OUT) plus one skid register (SKID), each holding {imm, tag, illegal, valid}.
- fire_in = in_valid & in_ready; fire_out = out_valid & out_ready.
- in_ready = ~SKID.valid. It depends only on registered state, with no combinational path from out_ready.
- Update rules, first match wins:
  - flush: OUT.valid ← 0 and SKID.valid ← 0; any fire_in in the same cycle is discarded and not counted.
  - SKID valid, and (OUT empty or fire_out): OUT ← SKID; SKID.valid ← 0.
  - fire_in, and (OUT empty or fire_out): OUT ← new entry.
  - fire_in, OUT valid and no fire_out: SKID ← new entry.
  - fire_out with no replacement: OUT.valid ← 0.
- Entries leave in strict acceptance order.
- err_cnt increments by 1 on every non-flushed fire_in with in_imm_src = 111. It holds at 2^CNT_W−1 and is cleared only by reset.
- The data fields of an invalid register hold their last values. out_imm is not required to be meaningful when out_valid = 0.

## Timing
- Reset (async assert, sync release): out_valid = 0, out_imm = 0, out_tag = 0, out_illegal = 0, err_cnt = 0, SKID empty.
- in_ready = 1 from reset assertion onward.
- Reset asserted mid-transfer clears everything immediately. Entries in flight are lost.
- Latency: an entry accepted at edge N appears with out_valid = 1 after edge N, i.e. in cycle N+1.
- Throughput: 1 entry per cycle while out_ready = 1.
- Backpressure:
  - The second entry accepted while out_ready = 0 fills SKID, and in_ready drops the following cycle.
  - At most 2 entries are held.
  - Once out_ready rises, in_ready returns 1 one cycle after the SKID→OUT move.
- Simultaneous fire_in and fire_out with SKID empty: the new entry replaces OUT with no bubble.
- While out_valid = 1 and out_ready = 0, out_imm, out_tag and out_illegal stay stable.
- Flush: out_valid = 0 and in_ready = 1 in the cycle after flush.

## Test plan
- XLEN=32, out_ready=1. Stream in this order:
  - 0xFFF00093 with src 000 → 0xFFFFFFFF
  - 0xFE000EE3 with src 010 → 0xFFFFFFFC
  - 0x123450B7 with src 011 → 0x12345000
  - 0x01F09093 with src 101 → 0x0000001F

  Each result appears one cycle after its input, back-to-back, and tags match.
- XLEN=64: 0x800000B7 with src 011 → 0xFFFFFFFF80000000. 0x03F09093 with src 101 → 0x000000000000003F.
- Backpressure: out_ready=0 while offering tags 1, 2, 3.
  - Tags 1 and 2 are accepted; in_ready is 0 in the cycle after tag 2 is accepted; tag 3 is held at the input.
  - Raise out_ready: tags emerge 1, 2, 3 on consecutive cycles, with no loss or duplication.
- Illegal select: src 111 with any instr → out_illegal=1, out_imm=0, err_cnt 0→1. With CNT_W=2, five illegal entries → err_cnt=3 (saturated).
- Flush with OUT and SKID both full, plus in_valid=1 in the same cycle → next cycle out_valid=0 and in_ready=1. The concurrent input is never output, and err_cnt is unchanged by it.
- Reset asserted while out_valid=1 and out_ready=0 → out_valid, out_imm and err_cnt are 0 without waiting for a clock edge. After release the stage accepts again with 1-cycle latency.

Source files
------------

// File: rtl/imm_extend_stage.sv
// Registered RV immediate-extension stage: decodes the immediate from a 32-bit
// instruction and delivers it one cycle later through a 2-entry skid buffer.
module imm_extend_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_S     = 3'b001,
    FMT_B     = 3'b010,
    FMT_U     = 3'b011,
    FMT_J     = 3'b100,
    FMT_SHAMT = 3'b101,
    FMT_ZIMM  = 3'b110,
    FMT_ILL   = 3'b111
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic             valid;
  } entry_t;

  entry_t           out_q, out_d;
  entry_t           skid_q, skid_d;
  entry_t           new_e;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      ext;
  logic             fire_in;
  logic             fire_out;
  logic             out_free;
  imm_fmt_e         fmt;

  assign fmt = imm_fmt_e'(in_imm_src);

  // Every format is built at 64 bits and truncated, so one table serves both XLENs.
  // NOTE: every variable driven in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    ext = '0;
    unique case (fmt)
      FMT_I:     ext = {{52{in_instr[31]}}, in_instr[31:20]};
      FMT_S:     ext = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:     ext = {{52{in_instr[31]}}, in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      FMT_U:     ext = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
      FMT_J:     ext = {{44{in_instr[31]}}, in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      FMT_SHAMT: ext = (XLEN == 64) ? {58'b0, in_instr[25:20]}
                                    : {59'b0, in_instr[24:20]};
      FMT_ZIMM:  ext = {59'b0, in_instr[19:15]};
      FMT_ILL:   ext = '0;
      default:   ext = '0;
    endcase
  end

  always_comb begin
    new_e         = '0;
    new_e.imm     = ext[XLEN-1:0];
    new_e.tag     = in_tag;
    new_e.illegal = (fmt == FMT_ILL);
    new_e.valid   = 1'b1;
  end

  // in_ready comes from registered state only; the skid slot absorbs the
  // one-cycle lag of a stall seen on out_ready.
  assign in_ready = ~skid_q.valid;
  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_q.valid & out_ready;
  assign out_free = ~out_q.valid | fire_out;

  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    cnt_d  = cnt_q;
    if (flush) begin
      out_d.valid  = 1'b0;
      skid_d.valid = 1'b0;
    end else begin
      if (skid_q.valid && out_free) begin
        out_d        = skid_q;
        skid_d.valid = 1'b0;
      end else if (fire_in && out_free) begin
        out_d = new_e;
      end else if (fire_in) begin
        skid_d = new_e;
      end else if (fire_out) begin
        out_d.valid = 1'b0;
      end

      if (fire_in && new_e.illegal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: data fields are reset too, because out_imm/out_tag must read 0 during reset.
  // NOTE: non-blocking (<=) in always_ff so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid   = out_q.valid;
  assign out_imm     = out_q.imm;
  assign out_tag     = out_q.tag;
  assign out_illegal = out_q.illegal;
  assign err_cnt     = cnt_q;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: an XLEN=32/CNT_W=2 and an XLEN=64/CNT_W=8 instance
// share one input stream; a queue-based model checks both every cycle.
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_imm_a;
  logic [3:0]  out_tag_a;
  logic [1:0]  err_cnt_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_imm_b;
  logic [3:0]  out_tag_b;
  logic [7:0]  err_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [3:0]  tag;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   cnt_a = 0;
  int   cnt_b = 0;

  always #5 clk = ~clk;

  imm_extend_stage #(.XLEN(32), .TAG_W(4), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_imm(out_imm_a), .out_tag(out_tag_a),
    .out_illegal(out_illegal_a), .err_cnt(err_cnt_a)
  );

  imm_extend_stage #(.XLEN(64), .TAG_W(4), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_imm(out_imm_b), .out_tag(out_tag_b),
    .out_illegal(out_illegal_b), .err_cnt(err_cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference immediate from the format rules, using plain integer arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          input int xlen);
    longint u;
    longint v;
    u = longint'({32'b0, ins});
    v = 0;
    case (src)
      3'd0: begin v = (u >> 20) & 'hFFF; if (v >= 2048) v -= 4096; end
      3'd1: begin
        v = (((u >> 25) & 'h7F) << 5) | ((u >> 7) & 'h1F);
        if (v >= 2048) v -= 4096;
      end
      3'd2: begin
        v = (((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
            (((u >> 25) & 'h3F) << 5) | (((u >> 8) & 'hF) << 1);
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin v = u & 'hFFFFF000; if (v >= 64'h80000000) v -= 64'h100000000; end
      3'd4: begin
        v = (((u >> 31) & 1) << 20) | (((u >> 12) & 'hFF) << 12) |
            (((u >> 20) & 1) << 11) | (((u >> 21) & 'h3FF) << 1);
        if (v >= 64'h100000) v -= 64'h200000;
      end
      3'd5: v = (u >> 20) & ((xlen == 64) ? 63 : 31);
      3'd6: v = (u >> 15) & 31;
      default: v = 0;
    endcase
    if (xlen == 64) return 64'(v);
    return {32'b0, v[31:0]};
  endfunction

  // Scoreboard: held entries live in q; checks handshake, ordering, data and counters.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      automatic logic rdy_m = (q.size() < 2);
      check("in_ready_a", 64'(in_ready_a), 64'(rdy_m));
      check("in_ready_b", 64'(in_ready_b), 64'(rdy_m));
      check("out_valid_a", 64'(out_valid_a), 64'(q.size() > 0));
      check("out_valid_b", 64'(out_valid_b), 64'(q.size() > 0));
      check("err_cnt_a", 64'(err_cnt_a), 64'(cnt_a));
      check("err_cnt_b", 64'(err_cnt_b), 64'(cnt_b));
      if (q.size() > 0) begin
        check("imm_a", 64'(out_imm_a), q[0].imm32);
        check("imm_b", out_imm_b, q[0].imm64);
        check("tag_a", 64'(out_tag_a), 64'(q[0].tag));
        check("tag_b", 64'(out_tag_b), 64'(q[0].tag));
        check("ill_a", 64'(out_illegal_a), 64'(q[0].ill));
        check("ill_b", 64'(out_illegal_b), 64'(q[0].ill));
        if (out_ready) void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && rdy_m) begin
        automatic exp_t e;
        e.imm32 = ref_imm(in_instr, in_imm_src, 32);
        e.imm64 = ref_imm(in_instr, in_imm_src, 64);
        e.tag   = in_tag;
        e.ill   = (in_imm_src == 3'b111);
        q.push_back(e);
        if (e.ill) begin
          if (cnt_a < 3)   cnt_a++;
          if (cnt_b < 255) cnt_b++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] s,
                       input logic [3:0] t);
    in_valid   = v;
    in_instr   = ins;
    in_imm_src = s;
    in_tag     = t;
  endtask

  logic [31:0] d_ins [4] = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h01F09093};
  logic [2:0]  d_src [4] = '{3'b000, 3'b010, 3'b011, 3'b101};
  logic [31:0] d_exp [4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h0000001F};

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    #3;
    check("rst_valid", 64'(out_valid_a), 64'd0);
    check("rst_imm", 64'(out_imm_a), 64'd0);
    check("rst_tag", 64'(out_tag_a), 64'd0);
    check("rst_ill", 64'(out_illegal_a), 64'd0);
    check("rst_cnt", 64'(err_cnt_a), 64'd0);
    check("rst_ready", 64'(in_ready_a), 64'd1);
    #19 rst_n = 1'b1;
    tick();

    // Back-to-back stream, XLEN=32, result one cycle after each input.
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1'b1, d_ins[k], d_src[k], 4'(k + 5));
      else       drive(1'b0, '0, '0, '0);
      @(negedge clk);
      if (k > 0) begin
        check("str_valid", 64'(out_valid_a), 64'd1);
        check("str_imm", 64'(out_imm_a), 64'(d_exp[k-1]));
        check("str_tag", 64'(out_tag_a), 64'(k + 4));
      end
      tick();
    end

    // XLEN=64 sign extension of U and 6-bit shamt.
    drive(1'b1, 32'h800000B7, 3'b011, 4'd1);
    tick();
    drive(1'b1, 32'h03F09093, 3'b101, 4'd2);
    @(negedge clk);
    check("x64_u", out_imm_b, 64'hFFFFFFFF80000000);
    tick();
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    check("x64_shamt", out_imm_b, 64'h000000000000003F);
    tick();

    // Illegal select and counter saturation (CNT_W=2 on dut_a).
    check("ill_cnt0", 64'(err_cnt_a), 64'd0);
    drive(1'b1, $urandom, 3'b111, 4'd3);
    tick();
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    check("ill_flag", 64'(out_illegal_a), 64'd1);
    check("ill_imm", 64'(out_imm_a), 64'd0);
    check("ill_cnt1", 64'(err_cnt_a), 64'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, $urandom, 3'b111, 4'(k));
      tick();
    end
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    check("ill_sat_a", 64'(err_cnt_a), 64'd3);
    check("ill_cnt_b", 64'(err_cnt_b), 64'd5);
    tick();

    // Backpressure: tags 1,2 accepted, 3 held, then drained in order.
    out_ready = 1'b0;
    drive(1'b1, $urandom, 3'b000, 4'd1);
    tick();
    drive(1'b1, $urandom, 3'b000, 4'd2);
    tick();
    drive(1'b1, $urandom, 3'b000, 4'd3);
    @(negedge clk);
    check("bp_ready_drop", 64'(in_ready_a), 64'd0);
    tick();
    @(negedge clk);
    check("bp_ready_hold", 64'(in_ready_a), 64'd0);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_tag1", 64'(out_tag_a), 64'd1);
    tick();
    @(negedge clk);
    check("bp_tag2", 64'(out_tag_a), 64'd2);
    check("bp_ready_back", 64'(in_ready_a), 64'd1);
    tick();
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    check("bp_tag3", 64'(out_tag_a), 64'd3);
    check("bp_valid3", 64'(out_valid_a), 64'd1);
    tick();
    @(negedge clk);
    check("bp_empty", 64'(out_valid_a), 64'd0);
    tick();

    // Flush with both slots full and an input offered.
    out_ready = 1'b0;
    drive(1'b1, $urandom, 3'b001, 4'd4);
    tick();
    drive(1'b1, $urandom, 3'b001, 4'd5);
    tick();
    drive(1'b1, $urandom, 3'b111, 4'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    check("fl_valid", 64'(out_valid_a), 64'd0);
    check("fl_ready", 64'(in_ready_a), 64'd1);
    check("fl_cnt", 64'(err_cnt_b), 64'd5);
    tick();

    // Flush with only OUT full: the concurrent illegal input is accepted then discarded.
    drive(1'b1, $urandom, 3'b000, 4'd7);
    tick();
    drive(1'b1, $urandom, 3'b111, 4'd8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    @(negedge clk);
    check("fl2_valid", 64'(out_valid_a), 64'd0);
    check("fl2_cnt", 64'(err_cnt_b), 64'd5);
    tick();
    @(negedge clk);
    check("fl2_no_out", 64'(out_valid_a), 64'd0);
    tick();

    // Asynchronous reset while an entry is stalled at the output.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'b000, 4'd9);
    tick();
    drive(1'b0, '0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid_a), 64'd0);
    check("arst_imm", 64'(out_imm_a), 64'd0);
    check("arst_tag", 64'(out_tag_a), 64'd0);
    check("arst_cnt_a", 64'(err_cnt_a), 64'd0);
    check("arst_cnt_b", 64'(err_cnt_b), 64'd0);
    check("arst_ready", 64'(in_ready_a), 64'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    drive(1'b1, 32'h123450B7, 3'b011, 4'd10);
    tick();
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    check("arst_lat_valid", 64'(out_valid_a), 64'd1);
    check("arst_lat_imm", 64'(out_imm_a), 64'h12345000);
    check("arst_lat_tag", 64'(out_tag_a), 64'd10);
    tick();

    // Randomized traffic with random backpressure and occasional flush.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
